obuftds_bus_sched: RTL and testbench



---
 rtl/obuftds_sched_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/obuftds_bus_sched.sv | 87 ++++++++
 tb/tb_obuftds_bus_sched.sv | 117 +++++++++++
 4 files changed

// File: rtl/obuftds_sched_pkg.sv
// obuftds_sched_pkg: shared state type and default sizing for the OBUFTDS bus scheduler
package obuftds_sched_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_LEN_W      = 4;
    localparam int DEF_TURNAROUND = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first active request at or after ptr, wrapping modulo NUM_REQ
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         win,
    output logic [$clog2(NUM_REQ)-1:0] win_idx,
    output logic                       any
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] j;

    always_comb begin
        win_idx = '0;
        any     = 1'b0;
        j       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[j]) begin
                any     = 1'b1;
                win_idx = j;
            end
        end
    end

    assign win = any ? NUM_REQ'(1) << win_idx : '0;

endmodule

// File: rtl/obuftds_bus_sched.sv
// obuftds_bus_sched: round-robin owner of one OBUFTDS pair, serial bursts separated by high-Z turnaround
module obuftds_bus_sched
    import obuftds_sched_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int TURNAROUND = DEF_TURNAROUND
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hiz,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]       data_ack,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     buf_i,
    output logic                     buf_t
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TC_W  = TURNAROUND > 1 ? $clog2(TURNAROUND) : 1;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, win_idx;
    logic [NUM_REQ-1:0] win;
    logic               any, arb;
    logic [LEN_W-1:0]   cnt, win_len;
    logic [TC_W-1:0]    tcnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .win    (win),
        .win_idx(win_idx),
        .any    (any)
    );

    assign arb     = state == IDLE && !hiz && any;
    assign win_len = req_len[win_idx*LEN_W +: LEN_W];

    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state == IDLE  ? (arb ? DRIVE : IDLE)
                  : state == DRIVE ? (cnt == '0 ? TURN : DRIVE)
                  : (tcnt == '0 ? IDLE : TURN);
    end

    always_comb begin
        busy     = state != IDLE;
        data_ack = state == DRIVE ? grant : '0;
    end

    // Pad pins follow the state one cycle late, so the last bit is still driven in the first TURN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= '0;
            ptr   <= '0;
            cnt   <= '0;
            tcnt  <= '0;
            buf_i <= 1'b0;
            buf_t <= 1'b1;
        end else begin
            buf_t <= state != DRIVE;
            buf_i <= state == DRIVE && |(req_data & grant);
            if (arb) begin
                grant <= win;
                cnt   <= win_len == '0 ? '0 : win_len - 1'b1;
                ptr   <= win_idx == PTR_W'(NUM_REQ - 1) ? '0 : win_idx + 1'b1;
            end
            if (state == DRIVE) begin
                if (cnt != '0) cnt <= cnt - 1'b1;
                else tcnt <= TC_W'(TURNAROUND - 1);
            end
            if (state == TURN) begin
                if (tcnt != '0) tcnt <= tcnt - 1'b1;
                else grant <= '0;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    assert property (@(posedge clk) disable iff (rst) !buf_t |-> grant != '0);

endmodule

// File: tb/tb_obuftds_bus_sched.sv
// tb_obuftds_bus_sched: per-cycle expectation scoreboard for the OBUFTDS bus scheduler
module tb_obuftds_bus_sched;

    localparam int NUM_REQ    = 2;
    localparam int LEN_W      = 4;
    localparam int TURNAROUND = 2;

    typedef logic [6:0] exp_t;

    logic       clk = 1'b0;
    logic       rst, hiz, busy, buf_i, buf_t, b0;
    logic [1:0] req, req_data, data_ack, grant;
    logic [7:0] req_len;
    int         checks = 0, failures = 0, n = 0;
    string      phase;
    exp_t       exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    obuftds_bus_sched #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .TURNAROUND(TURNAROUND)) dut (
        .clk     (clk),
        .rst     (rst),
        .hiz     (hiz),
        .req     (req),
        .req_len (req_len),
        .req_data(req_data),
        .data_ack(data_ack),
        .grant   (grant),
        .busy    (busy),
        .buf_i   (buf_i),
        .buf_t   (buf_t)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: {grant,buf_t,buf_i,busy,data_ack} got %b want %b", tag, obs[6:0], exp[6:0]);
        end
    endtask

    always @(negedge clk)
        if (exp_q.size() != 0)
            check(tag_q.pop_front(), {1'b0, grant, buf_t, buf_i, busy, data_ack}, {1'b0, exp_q.pop_front()});

    task automatic cy(input logic [1:0] r, input logic [1:0] d, input logic h, input logic rs,
                      input logic [1:0] g, input logic bt, input logic bi, input logic bsy, input logic [1:0] ack);
        req      = r;
        req_data = d;
        hiz      = h;
        rst      = rs;
        exp_q.push_back({g, bt, bi, bsy, ack});
        tag_q.push_back($sformatf("%s#%0d", phase, n++));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] r, input logic h, input int k);
        for (int i = 0; i < k; i++) cy(r, 2'($urandom), h, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic burst(input logic [1:0] ar, input logic [1:0] lr, input logic lh,
                         input logic [1:0] g, input int len, input logic [15:0] bits);
        cy(ar, 2'($urandom), 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00);
        req_len = 8'($urandom);
        for (int i = 0; i < len; i++)
            cy(lr, (2'($urandom) & ~g) | (bits[i] ? g : 2'b00), lh, 1'b0,
               g, i == 0, i == 0 ? 1'b0 : bits[i-1], 1'b1, g);
        cy(lr, 2'($urandom), lh, 1'b0, g, 1'b0, bits[len-1], 1'b1, 2'b00);
        for (int t = 1; t < TURNAROUND; t++) cy(lr, 2'($urandom), lh, 1'b0, g, 1'b1, 1'b0, 1'b1, 2'b00);
    endtask

    initial begin
        rst = 1'b1; hiz = 1'b0; req = '0; req_data = '0; req_len = '0;
        phase = "reset";
        repeat (2) @(posedge clk);
        #1;
        idle(2'b00, 1'b0, 2);
        phase = "single";
        req_len = {4'd7, 4'd3};
        burst(2'b01, 2'b00, 1'b0, 2'b01, 3, 16'b101);
        idle(2'b00, 1'b0, 1);
        phase = "len0";
        req_len = {4'd0, 4'd9};
        burst(2'b10, 2'b00, 1'b0, 2'b10, 1, 16'($urandom));
        idle(2'b00, 1'b0, 1);
        phase = "rr";
        for (int k = 0; k < 4; k++) begin
            req_len = {4'd2, 4'd2};
            burst(2'b11, 2'b11, 1'b0, k % 2 == 0 ? 2'b01 : 2'b10, 2, 16'($urandom));
        end
        phase = "pulse";
        req_len = {4'd1, 4'd5};
        burst(2'b01, 2'b00, 1'b1, 2'b01, 5, 16'($urandom));
        idle(2'b00, 1'b0, 1);
        phase = "hiz";
        idle(2'b11, 1'b1, 4);
        req_len = {4'd2, 4'd3};
        burst(2'b11, 2'b00, 1'b0, 2'b10, 2, 16'($urandom));
        idle(2'b00, 1'b0, 1);
        phase = "rst";
        req_len = {4'd4, 4'd6};
        b0 = 1'($urandom);
        cy(2'b01, 2'($urandom), 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00);
        cy(2'b00, {1'($urandom), b0}, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01);
        cy(2'b00, 2'($urandom), 1'b0, 1'b1, 2'b01, 1'b0, b0, 1'b1, 2'b01);
        idle(2'b00, 1'b0, 2);
        phase = "ptr";
        req_len = {4'd3, 4'd1};
        burst(2'b11, 2'b00, 1'b0, 2'b01, 1, 16'($urandom));
        idle(2'b00, 1'b0, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
